// File: rtl/sig_mag_dec.sv
// Sign/magnitude sample decoder with per-channel integrate-and-dump.
// Define SIG_MAG_DEC_STAT_EN to build the magnitude-duty monitor.
module sig_mag_dec #(
    parameter int unsigned WIDTH    = 14,
    parameter int unsigned N_CH     = 1,
    parameter int unsigned DEC_LOG2 = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [N_CH-1:0]       sig,
    input  logic [N_CH-1:0]       mag,
    input  logic [3:0]            w_hi,
    output logic [N_CH*WIDTH-1:0] data_out,
    output logic                  valid,
    output logic [N_CH*10-1:0]    mag_cnt,
    output logic [N_CH-1:0]       mag_ok,
    output logic                  stat_valid
);

    localparam int unsigned AW = 5 + DEC_LOG2;
    localparam int unsigned CW = (DEC_LOG2 == 0) ? 1 : DEC_LOG2;

    logic [CW-1:0]         dec_cntr_q, dec_cntr_d;
    logic signed [AW-1:0]  acc_q [N_CH];
    logic signed [AW-1:0]  acc_d [N_CH];
    logic signed [4:0]     level [N_CH];
    logic signed [AW-1:0]  sum   [N_CH];
    logic [N_CH*WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  block_end;

    // With DEC_LOG2=0 every strobe closes a block, so the counter value is irrelevant.
    assign block_end = (DEC_LOG2 == 0) || (dec_cntr_q == {CW{1'b1}});

    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            level[i] = mag[i] ? $signed({1'b0, w_hi}) : 5'sd1;
            if (sig[i]) begin
                level[i] = -level[i];
            end
            sum[i] = acc_q[i] + AW'(level[i]);
        end
    end

    always_comb begin
        dec_cntr_d = dec_cntr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            acc_d[i] = acc_q[i];
        end
        if (we) begin
            dec_cntr_d = dec_cntr_q + CW'(1);
            if (block_end) begin
                valid_d = 1'b1;
                for (int i = 0; i < int'(N_CH); i++) begin
                    // Channel 0 occupies the most significant slice.
                    data_d[(int'(N_CH) - 1 - i) * int'(WIDTH) +: WIDTH] = WIDTH'(sum[i]);
                    acc_d[i] = '0;
                end
            end else begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    acc_d[i] = sum[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            dec_cntr_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            dec_cntr_q <= dec_cntr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;

`ifdef SIG_MAG_DEC_STAT_EN
    logic [9:0]          win_cntr_q, win_cntr_d;
    logic [9:0]          mag_acc_q [N_CH];
    logic [9:0]          mag_acc_d [N_CH];
    logic [9:0]          mag_next  [N_CH];
    logic [N_CH*10-1:0]  mag_cnt_q, mag_cnt_d;
    logic [N_CH-1:0]     mag_ok_q, mag_ok_d;
    logic                stat_valid_q, stat_valid_d;

    always_comb begin
        win_cntr_d   = win_cntr_q;
        mag_cnt_d    = mag_cnt_q;
        mag_ok_d     = mag_ok_q;
        stat_valid_d = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            mag_next[i]  = mag_acc_q[i] + 10'(mag[i]);
            mag_acc_d[i] = mag_acc_q[i];
        end
        if (we) begin
            win_cntr_d = win_cntr_q + 10'd1;
            if (win_cntr_q == 10'd1023) begin
                stat_valid_d = 1'b1;
                for (int i = 0; i < int'(N_CH); i++) begin
                    mag_cnt_d[(int'(N_CH) - 1 - i) * 10 +: 10] = mag_next[i];
                    mag_ok_d[i]  = (mag_next[i] >= 10'd256) && (mag_next[i] <= 10'd448);
                    mag_acc_d[i] = '0;
                end
            end else begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    mag_acc_d[i] = mag_next[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            win_cntr_q   <= '0;
            mag_cnt_q    <= '0;
            mag_ok_q     <= '0;
            stat_valid_q <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                mag_acc_q[i] <= '0;
            end
        end else begin
            win_cntr_q   <= win_cntr_d;
            mag_cnt_q    <= mag_cnt_d;
            mag_ok_q     <= mag_ok_d;
            stat_valid_q <= stat_valid_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                mag_acc_q[i] <= mag_acc_d[i];
            end
        end
    end

    assign mag_cnt    = mag_cnt_q;
    assign mag_ok     = mag_ok_q;
    assign stat_valid = stat_valid_q;
`else
    assign mag_cnt    = '0;
    assign mag_ok     = '0;
    assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sig_mag_dec.sv
// Scoreboard bench for sig_mag_dec: three instances (DEC_LOG2 = 0, 2, 8) share one stimulus.
module tb_sig_mag_dec;

    localparam int NC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clr = 1'b0;
    logic          we = 1'b0;
    logic [NC-1:0] sig = '0;
    logic [NC-1:0] mag = '0;
    logic [3:0]    w_hi = 4'd3;

    logic [NC*14-1:0] d0, d2;
    logic [NC*13-1:0] d8;
    logic             v0, v2, v8, sv0, sv2, sv8;
    logic [NC*10-1:0] mc0, mc2, mc8;
    logic [NC-1:0]    ok0, ok2, ok8;

    sig_mag_dec #(.WIDTH(14), .N_CH(NC), .DEC_LOG2(0)) u0 (
        .clk(clk), .clr(clr), .we(we), .sig(sig), .mag(mag), .w_hi(w_hi),
        .data_out(d0), .valid(v0), .mag_cnt(mc0), .mag_ok(ok0), .stat_valid(sv0)
    );
    sig_mag_dec #(.WIDTH(14), .N_CH(NC), .DEC_LOG2(2)) u2 (
        .clk(clk), .clr(clr), .we(we), .sig(sig), .mag(mag), .w_hi(w_hi),
        .data_out(d2), .valid(v2), .mag_cnt(mc2), .mag_ok(ok2), .stat_valid(sv2)
    );
    sig_mag_dec #(.WIDTH(13), .N_CH(NC), .DEC_LOG2(8)) u8 (
        .clk(clk), .clr(clr), .we(we), .sig(sig), .mag(mag), .w_hi(w_hi),
        .data_out(d8), .valid(v8), .mag_cnt(mc8), .mag_ok(ok8), .stat_valid(sv8)
    );

    typedef struct {
        int due;
        int c0;
        int c1;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t q8[$];
    exp_t sq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit run = 1'b0;
    bit rst_chk = 1'b0;
    bit end_chk = 1'b0;
    bit e0, e2, e8, es;

    int dl[3] = '{0, 2, 8};
    int acc[3][2];
    int cnt[3];
`ifdef SIG_MAG_DEC_STAT_EN
    int win = 0;
    int macc[2];
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int lvl(input bit s, input bit m);
        int v;
        v = m ? int'(w_hi) : 1;
        return s ? -v : v;
    endfunction

    function automatic int okv(input int c);
        return (c >= 256 && c <= 448) ? 1 : 0;
    endfunction

    // Drive one cycle of stimulus and advance the reference model.
    task automatic step(input bit c, input bit w, input bit s0, input bit m0,
                        input bit s1, input bit m1);
        exp_t e;
        @(posedge clk);
        #1;
        clr = c;
        we  = w;
        sig = {s1, s0};
        mag = {m1, m0};
        if (c) begin
            for (int k = 0; k < 3; k++) begin
                cnt[k] = 0;
                acc[k][0] = 0;
                acc[k][1] = 0;
            end
`ifdef SIG_MAG_DEC_STAT_EN
            win = 0;
            macc[0] = 0;
            macc[1] = 0;
`endif
        end else if (w) begin
            for (int k = 0; k < 3; k++) begin
                acc[k][0] += lvl(s0, m0);
                acc[k][1] += lvl(s1, m1);
                if (cnt[k] == (1 << dl[k]) - 1) begin
                    e.due = cyc + 1;
                    e.c0  = acc[k][0];
                    e.c1  = acc[k][1];
                    if (k == 0) q0.push_back(e);
                    else if (k == 1) q2.push_back(e);
                    else q8.push_back(e);
                    acc[k][0] = 0;
                    acc[k][1] = 0;
                    cnt[k] = 0;
                end else begin
                    cnt[k]++;
                end
            end
`ifdef SIG_MAG_DEC_STAT_EN
            macc[0] += int'(m0);
            macc[1] += int'(m1);
            if (win == 1023) begin
                e.due = cyc + 1;
                e.c0  = macc[0] & 1023;
                e.c1  = macc[1] & 1023;
                sq.push_back(e);
                macc[0] = 0;
                macc[1] = 0;
                win = 0;
            end else begin
                win++;
            end
`endif
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (run) begin
            e0 = (q0.size() != 0) && (q0[0].due == cyc);
            e2 = (q2.size() != 0) && (q2[0].due == cyc);
            e8 = (q8.size() != 0) && (q8[0].due == cyc);
            es = (sq.size() != 0) && (sq[0].due == cyc);
            check("valid_d0", v0, e0);
            check("valid_d2", v2, e2);
            check("valid_d8", v8, e8);
            if (e0) begin
                check("d0_ch0", $signed(d0[27:14]), q0[0].c0);
                check("d0_ch1", $signed(d0[13:0]), q0[0].c1);
                void'(q0.pop_front());
            end
            if (e2) begin
                check("d2_ch0", $signed(d2[27:14]), q2[0].c0);
                check("d2_ch1", $signed(d2[13:0]), q2[0].c1);
                void'(q2.pop_front());
            end
            if (e8) begin
                check("d8_ch0", $signed(d8[25:13]), q8[0].c0);
                check("d8_ch1", $signed(d8[12:0]), q8[0].c1);
                void'(q8.pop_front());
            end
            check("stat_valid_d0", sv0, es);
            check("stat_valid_d2", sv2, es);
            check("stat_valid_d8", sv8, es);
`ifdef SIG_MAG_DEC_STAT_EN
            if (es) begin
                check("mag_cnt_ch0", mc0[19:10], sq[0].c0);
                check("mag_cnt_ch1", mc0[9:0], sq[0].c1);
                check("mag_ok_ch0", ok0[0], okv(sq[0].c0));
                check("mag_ok_ch1", ok0[1], okv(sq[0].c1));
                check("mag_cnt_d2", (mc2 == mc0) ? 1 : 0, 1);
                check("mag_cnt_d8", (mc8 == mc0) ? 1 : 0, 1);
                check("mag_ok_d2_d8", (ok2 == ok0 && ok8 == ok0) ? 1 : 0, 1);
                void'(sq.pop_front());
            end
`else
            check("mon_tied_d0", (mc0 == '0 && ok0 == '0) ? 0 : 1, 0);
            check("mon_tied_d2", (mc2 == '0 && ok2 == '0) ? 0 : 1, 0);
            check("mon_tied_d8", (mc8 == '0 && ok8 == '0) ? 0 : 1, 0);
`endif
            if (rst_chk) begin
                check("rst_data_d0", (d0 == '0) ? 0 : 1, 0);
                check("rst_data_d2", (d2 == '0) ? 0 : 1, 0);
                check("rst_data_d8", (d8 == '0) ? 0 : 1, 0);
                check("rst_mag_cnt", (mc0 == '0 && mc2 == '0 && mc8 == '0) ? 0 : 1, 0);
                check("rst_mag_ok", (ok0 == '0 && ok2 == '0 && ok8 == '0) ? 0 : 1, 0);
            end
            if (end_chk) begin
                check("pending_outputs", q0.size() + q2.size() + q8.size() + sq.size(), 0);
            end
        end
    end

    initial begin
        // Reset and reset-value check.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run = 1'b1;
        rst_chk = 1'b1;
        idle();
        rst_chk = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Level map, back-to-back strobes, w_hi = 3.
        w_hi = 4'd3;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        // Integrate over 4 strobes.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // Partial block dropped by clr; clr with we discards the sample.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            idle();
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Extremes at w_hi = 15 over 256-strobe blocks.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        w_hi = 4'd15;
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle();
        idle();

        // Duty monitor windows: 342/0, then 0/256.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        w_hi = 4'd3;
        for (int i = 0; i < 1024; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(1)), (i % 3) == 0, 1'($urandom_range(1)), 1'b0);
        end
        idle();
        for (int i = 0; i < 1024; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), (i % 4) == 0);
            if (i == 500) idle();
        end
        idle();
        idle();
        idle();

        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sig_mag_dec.md
# sig_mag_dec

Sign/magnitude decoder and integrator for the 2-bit sample streams produced by the adaptive sign/magnitude quantizers in the DSP chain. Each channel's (sig, mag) pair maps to a signed level ±1 / ±W_HI, then integrate-and-dump over 2^DEC_LOG2 input strobes gives a signed WIDTH-bit output. It sits at the consuming end of the quantized link: correlator inputs, loopback checks and record playback. An optional monitor measures the magnitude-bit duty per channel so firmware can confirm the upstream threshold loop has converged (target ≈1/3).

## Interface
- Reset is synchronous and active-high; the clock is `clk` and the reset is `clr`.
- WIDTH, 14, output sample width per channel (signed); must be ≥ 5+DEC_LOG2.
- N_CH, 1, number of channels.
- DEC_LOG2, 0, log2 of the integrate-and-dump length (0..8).
- clk  in  1  clock.
- clr  in  1  synchronous active-high reset.
- we  in  1  input sample strobe; sig/mag/w_hi are sampled when we=1.
- sig  in  N_CH  sign bit per channel; 1 = negative.
- mag  in  N_CH  magnitude bit per channel; 1 = high level.
- w_hi  in  4  unsigned high-level weight (runtime, typically 3).
- data_out  out  N_CH*WIDTH  signed integrated samples; ch0 in the MSBs (packed as `{>>{}}`).
- valid  out  1  one-cycle pulse; data_out is new.
- mag_cnt  out  N_CH*10  per-channel count of mag=1 in the last 1024-sample window.
- mag_ok  out  N_CH  per-channel flag; 1 if mag_cnt is in [256,448].
- stat_valid  out  1  one-cycle pulse; mag_cnt/mag_ok updated.

## Operation
- Level map per channel, at we: mag=0 → ±1; mag=1 → ±w_hi (zero-extended); sig=1 negates. w_hi=0 gives 0 for high samples (legal).
- Accumulator per channel, signed, 5+DEC_LOG2 bits. It cannot overflow: |sum| ≤ 15·2^DEC_LOG2.
- dec_cntr: DEC_LOG2-bit counter that increments on each we and wraps.
- On a we with dec_cntr = all-ones (always true when DEC_LOG2=0):
  - data_out gets acc + current level, sign-extended to WIDTH.
  - acc is cleared to 0.
  - valid is asserted next cycle.
- On any other we: acc += level.
- Monitor: 10-bit win_cntr increments on each we. mag_acc[i] increments on we & mag[i].
- On a we with win_cntr = 1023:
  - mag_cnt[i] gets mag_acc[i] + mag[i].
  - mag_ok is updated from that value.
  - mag_acc is cleared.
  - stat_valid pulses.
- we=0 cycles have no effect; gaps between strobes of any length are allowed.

## Timing
- Reset values: data_out=0, valid=0, mag_cnt=0, mag_ok=0, stat_valid=0. All internal counters and accumulators are 0.
- Latency: data_out and valid are registered on the clk edge of the final we of a block, so they are visible 1 cycle after that we. valid is high exactly 1 cycle.
- data_out holds its value until the next block completes.
- Back-to-back we at full clock rate with DEC_LOG2=0 gives valid high continuously, with new data each cycle.
- clr has priority over we in the same cycle. The sample is discarded and all counters return to 0, so the next block starts aligned to the first we after clr.
- clr mid-block drops the partial sum; no valid is produced for it.
- stat_valid and valid may coincide. Both follow the same one-cycle registered rule.

## Configuration
- Macro `SIG_MAG_DEC_STAT_EN`.
- Defined: the duty monitor is built (win_cntr, mag_acc, mag_cnt, mag_ok, stat_valid as above).
- Undefined: no monitor logic is built. mag_cnt, mag_ok and stat_valid are tied to 0. The port list is unchanged.

## Test plan
- Map check, DEC_LOG2=0, w_hi=3: drive (sig,mag) = 00,01,10,11 on consecutive we → data_out = +1,+3,−1,−3. Each valid is 1 cycle after its we.
- Integrate, DEC_LOG2=2, w_hi=3: send 4 strobes of 01 → 12. Send 01,11,00,10 → 0. Exactly one valid per 4 we.
- Gapped/clr: DEC_LOG2=2; send 2 strobes of 01, clr, then 4 strobes of 00 → single output +4, no output for the partial block. clr with we in the same cycle ignores the sample.
- Extremes, DEC_LOG2=8, w_hi=15, WIDTH=13: 256 strobes of 11 → −3840 with no wrap; 256 strobes of 01 → +3840.
- Monitor (with SIG_MAG_DEC_STAT_EN): 1024 we with mag=1 on every 3rd sample starting at sample 0 → mag_cnt=342, mag_ok=1, stat_valid 1 cycle after the 1024th we. All-zero mag → mag_cnt=0, mag_ok=0.
- Without the macro: the same stimulus gives stat_valid, mag_cnt and mag_ok always 0. The data path matches the previous scenarios bit-for-bit.
